// File: rtl/control_unit_pkg.sv
// Shared definitions for the control unit: opcode constants, the FSM
// state encoding and the decoded control vector passed from cu_decode
// up to control_unit.
package control_unit_pkg;

    // Controller sequencing states
    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_HALTED = 2'd1,
        ST_STEP   = 2'd2
    } cu_state_t;

    // ALU instructions are recognised by opcode[5] alone
    localparam logic       OP_ALU_PFX   = 1'b1;
    // LOADI instructions are recognised by opcode[5:2]
    localparam logic [3:0] OP_LOADI_PFX = 4'b0000;

    // Fully decoded single opcodes
    localparam logic [5:0] OP_J    = 6'b000100;
    localparam logic [5:0] OP_JZ   = 6'b000101;
    localparam logic [5:0] OP_JNZ  = 6'b000110;
    localparam logic [5:0] OP_HALT = 6'b000111;

    // Control vector produced by the decoder for one instruction
    typedef struct packed {
        logic       s_inc;
        logic       s_inm;
        logic       we3;
        logic       wez;
        logic [2:0] op_alu;
        logic       is_halt;
        logic       is_illegal;
    } ctrl_t;

    // Vector that lets the PC advance with no side effects
    localparam ctrl_t CTRL_IDLE = '{
        s_inc:      1'b1,
        s_inm:      1'b0,
        we3:        1'b0,
        wez:        1'b0,
        op_alu:     3'b000,
        is_halt:    1'b0,
        is_illegal: 1'b0
    };

endpackage

// File: rtl/control_unit_decode.sv
// cu_decode: purely combinational opcode/zero-flag to control-vector
// decoder. It knows nothing about the debug FSM; control_unit gates its
// output according to the current state.
module cu_decode
    import control_unit_pkg::*;
(
    input  logic [5:0] opcode,
    input  logic       z,
    output ctrl_t      ctrl
);

    // Translate the instruction into enables; undefined opcodes fall through as a flagged NOP
    always_comb begin
        ctrl = CTRL_IDLE;
        if (opcode[5] == OP_ALU_PFX) begin
            ctrl.op_alu = opcode[4:2];
            ctrl.we3    = 1'b1;
            ctrl.wez    = 1'b1;
        end else if (opcode[5:2] == OP_LOADI_PFX) begin
            ctrl.we3   = 1'b1;
            ctrl.s_inm = 1'b1;
        end else begin
            case (opcode)
                OP_J:    ctrl.s_inc      = 1'b0;
                OP_JZ:   ctrl.s_inc      = ~z;
                OP_JNZ:  ctrl.s_inc      = z;
                OP_HALT: ctrl.is_halt    = 1'b1;
                default: ctrl.is_illegal = 1'b1;
            endcase
        end
    end

endmodule

// File: rtl/control_unit.sv
// control_unit: single-cycle processor controller with a RUN/HALTED/STEP
// debug FSM wrapped around the cu_decode instruction decoder.
// Optional feature: define CONTROL_UNIT_RETIRE_CNT_EN to add the
// CNT_W-bit retired-instruction counter and its 'retired' output port.
module control_unit
    import control_unit_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [5:0]       opcode,
    input  logic             z,
    input  logic             dbg_halt,
    input  logic             dbg_run,
    input  logic             dbg_step,
    output logic             s_inc,
    output logic             s_inm,
    output logic             we3,
    output logic             wez,
    output logic [2:0]       op_alu,
    output logic             pc_en,
    output logic             halted,
    output logic             illegal
`ifdef CONTROL_UNIT_RETIRE_CNT_EN
    ,
    output logic [CNT_W-1:0] retired
`endif
);

    cu_state_t state;
    cu_state_t state_next;
    ctrl_t     dec;
    logic      illegal_q;

    cu_decode u_decode (
        .opcode (opcode),
        .z      (z),
        .ctrl   (dec)
    );

    // State register; reset forces RUN regardless of any debug pulse
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_RUN;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: a HALT opcode and dbg_halt both end RUN after the current instruction
    always_comb begin
        state_next = state;
        case (state)
            ST_RUN: begin
                if (dec.is_halt || dbg_halt) begin
                    state_next = ST_HALTED;
                end
            end
            ST_HALTED: begin
                if (dbg_run) begin
                    state_next = ST_RUN;
                end else if (dbg_step) begin
                    state_next = ST_STEP;
                end
            end
            ST_STEP: begin
                state_next = ST_HALTED;
            end
            default: begin
                state_next = ST_RUN;
            end
        endcase
    end

    // Output gating: decoded enables pass only while an instruction actually executes
    always_comb begin
        s_inc  = 1'b1;
        s_inm  = 1'b0;
        we3    = 1'b0;
        wez    = 1'b0;
        op_alu = 3'b000;
        pc_en  = 1'b0;
        halted = 1'b0;
        if (!reset) begin
            if (state == ST_RUN || state == ST_STEP) begin
                s_inc  = dec.s_inc;
                s_inm  = dec.s_inm;
                we3    = dec.we3;
                wez    = dec.wez;
                op_alu = dec.op_alu;
                pc_en  = 1'b1;
            end else if (state == ST_HALTED) begin
                halted = 1'b1;
            end
        end
    end

    // Sticky undefined-opcode flag, set only by an executed instruction and cleared only by reset
    always_ff @(posedge clk) begin
        if (reset) begin
            illegal_q <= 1'b0;
        end else if (pc_en && dec.is_illegal) begin
            illegal_q <= 1'b1;
        end
    end

    assign illegal = illegal_q & ~reset;

`ifdef CONTROL_UNIT_RETIRE_CNT_EN
    logic [CNT_W-1:0] retired_q;

    // Retired-instruction counter: one per executing cycle, wrapping naturally at all-ones
    always_ff @(posedge clk) begin
        if (reset) begin
            retired_q <= '0;
        end else if (pc_en) begin
            retired_q <= retired_q + 1'b1;
        end
    end

    assign retired = reset ? '0 : retired_q;
`else
    logic unused_cnt_w;
    assign unused_cnt_w = (CNT_W > 0);
`endif

endmodule

// File: tb/tb_control_unit.sv
// Scoreboard bench for control_unit: stimulus pushes hand-computed expected
// control vectors into a queue, a negedge monitor pops and compares them.
module tb_control_unit;

    typedef struct packed {
        logic       s_inc;
        logic       s_inm;
        logic       we3;
        logic       wez;
        logic [2:0] op_alu;
        logic       pc_en;
        logic       halted;
        logic       illegal;
    } exp_t;

    typedef struct {
        exp_t       e;
        logic [3:0] ret;
        int         id;
    } sb_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [5:0] opcode = 6'b100100;
    logic       z = 1'b0;
    logic       dbg_halt = 1'b0;
    logic       dbg_run = 1'b0;
    logic       dbg_step = 1'b0;
    logic       s_inc, s_inm, we3, wez, pc_en, halted, illegal;
    logic [2:0] op_alu;
`ifdef CONTROL_UNIT_RETIRE_CNT_EN
    logic [3:0] retired;
`endif

    sb_t        sb_q[$];
    int         total = 0;
    int         bad = 0;
    int         vec_id = 0;
    logic [3:0] exp_ret = 4'd0;

    control_unit #(.CNT_W(4)) dut (
        .clk      (clk),
        .reset    (reset),
        .opcode   (opcode),
        .z        (z),
        .dbg_halt (dbg_halt),
        .dbg_run  (dbg_run),
        .dbg_step (dbg_step),
        .s_inc    (s_inc),
        .s_inm    (s_inm),
        .we3      (we3),
        .wez      (wez),
        .op_alu   (op_alu),
        .pc_en    (pc_en),
        .halted   (halted),
        .illegal  (illegal)
`ifdef CONTROL_UNIT_RETIRE_CNT_EN
        ,
        .retired  (retired)
`endif
    );

    always #5 clk = ~clk;

    function automatic exp_t mk(input logic si, input logic sm, input logic w3, input logic wz,
                                input logic [2:0] alu, input logic pe, input logic h, input logic il);
        exp_t e;
        e.s_inc   = si;
        e.s_inm   = sm;
        e.we3     = w3;
        e.wez     = wz;
        e.op_alu  = alu;
        e.pc_en   = pe;
        e.halted  = h;
        e.illegal = il;
        return e;
    endfunction

    function automatic exp_t rstv();
        return mk(1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
    endfunction

    function automatic exp_t alu(input logic [2:0] a, input logic il);
        return mk(1'b1, 1'b0, 1'b1, 1'b1, a, 1'b1, 1'b0, il);
    endfunction

    function automatic exp_t loadi(input logic il);
        return mk(1'b1, 1'b1, 1'b1, 1'b0, 3'd0, 1'b1, 1'b0, il);
    endfunction

    function automatic exp_t nop(input logic il);
        return mk(1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 1'b1, 1'b0, il);
    endfunction

    function automatic exp_t jmp(input logic taken, input logic il);
        return mk(~taken, 1'b0, 1'b0, 1'b0, 3'd0, 1'b1, 1'b0, il);
    endfunction

    function automatic exp_t haltd(input logic il);
        return mk(1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b1, il);
    endfunction

    task automatic applyStimulus(input logic rst, input logic [5:0] op, input logic zz,
                                 input logic dh, input logic dr, input logic ds, input exp_t e);
        sb_t item;
        @(posedge clk);
        #1;
        reset    = rst;
        opcode   = op;
        z        = zz;
        dbg_halt = dh;
        dbg_run  = dr;
        dbg_step = ds;
        item.e   = e;
        item.ret = rst ? 4'd0 : exp_ret;
        item.id  = vec_id;
        vec_id++;
        sb_q.push_back(item);
        if (rst) begin
            exp_ret = 4'd0;
        end else if (e.pc_en) begin
            exp_ret = exp_ret + 4'd1;
        end
    endtask

    task automatic checkOutput(input sb_t it);
        exp_t act;
        act = {s_inc, s_inm, we3, wez, op_alu, pc_en, halted, illegal};
        total++;
        if (act !== it.e) begin
            bad++;
            $display("[TB] FAIL vec%0d ctrl {s_inc,s_inm,we3,wez,op_alu,pc_en,halted,illegal}: got %b want %b",
                     it.id, act, it.e);
        end
`ifdef CONTROL_UNIT_RETIRE_CNT_EN
        total++;
        if (retired !== it.ret) begin
            bad++;
            $display("[TB] FAIL vec%0d retired: got %0d want %0d", it.id, retired, it.ret);
        end
`endif
    endtask

    // Monitor: every cycle carries one response, compared mid-cycle
    always @(negedge clk) begin
        if (sb_q.size() > 0) begin
            checkOutput(sb_q.pop_front());
        end
    end

    initial begin
        // reset held three cycles with an ALU opcode present
        for (int i = 0; i < 3; i++) applyStimulus(1, 6'b100100, 0, 0, 0, 0, rstv());
        applyStimulus(0, 6'b100100, 0, 0, 0, 0, alu(3'b001, 0));
        applyStimulus(0, 6'b000000, 0, 0, 0, 0, loadi(0));
        applyStimulus(0, 6'b000011, 1, 0, 0, 0, loadi(0));
        // conditional and unconditional jumps
        applyStimulus(0, 6'b000101, 1, 0, 0, 0, jmp(1, 0));
        applyStimulus(0, 6'b000101, 0, 0, 0, 0, jmp(0, 0));
        applyStimulus(0, 6'b000110, 0, 0, 0, 0, jmp(1, 0));
        applyStimulus(0, 6'b000110, 1, 0, 0, 0, jmp(0, 0));
        applyStimulus(0, 6'b000100, 0, 0, 0, 0, jmp(1, 0));
        applyStimulus(0, 6'b111110, 0, 0, 0, 0, alu(3'b111, 0));
        // dbg_run / dbg_step ignored while running
        applyStimulus(0, 6'b100011, 0, 0, 1, 1, alu(3'b000, 0));
        // HALT executes, then the unit stays halted through ALU opcodes
        applyStimulus(0, 6'b000111, 0, 0, 0, 0, nop(0));
        for (int i = 0; i < 5; i++)
            applyStimulus(0, (i % 2 == 0) ? 6'b100000 : 6'b110100, 0, 0, 0, 0, haltd(0));
        applyStimulus(0, 6'b100100, 0, 1, 0, 0, haltd(0));
        // single step of a LOADI, with pulses during STEP ignored
        applyStimulus(0, 6'b000000, 0, 0, 0, 1, haltd(0));
        applyStimulus(0, 6'b000000, 0, 1, 1, 0, loadi(0));
        applyStimulus(0, 6'b100100, 0, 0, 0, 0, haltd(0));
        applyStimulus(0, 6'b100100, 0, 0, 0, 0, haltd(0));
        // run and step together: run wins
        applyStimulus(0, 6'b100100, 0, 0, 1, 1, haltd(0));
        applyStimulus(0, 6'b100100, 0, 0, 0, 0, alu(3'b001, 0));
        applyStimulus(0, 6'b101000, 0, 0, 0, 0, alu(3'b010, 0));
        // dbg_halt lets the current instruction complete
        applyStimulus(0, 6'b101100, 0, 1, 0, 0, alu(3'b011, 0));
        applyStimulus(0, 6'b101100, 0, 0, 0, 0, haltd(0));
        // stepping a HALT still returns to HALTED
        applyStimulus(0, 6'b000000, 0, 0, 0, 1, haltd(0));
        applyStimulus(0, 6'b000111, 0, 0, 0, 0, nop(0));
        applyStimulus(0, 6'b100000, 0, 0, 0, 0, haltd(0));
        applyStimulus(0, 6'b100000, 0, 0, 1, 0, haltd(0));
        // HALT together with dbg_halt
        applyStimulus(0, 6'b000111, 0, 1, 0, 0, nop(0));
        applyStimulus(0, 6'b100000, 0, 0, 0, 0, haltd(0));
        applyStimulus(0, 6'b100000, 0, 0, 1, 0, haltd(0));
        // undefined opcode runs as a NOP and sets the sticky flag
        applyStimulus(0, 6'b010011, 0, 0, 0, 0, nop(0));
        for (int i = 0; i < 10; i++) begin
            if (i % 2 == 0) applyStimulus(0, 6'b100100, 0, 0, 0, 0, alu(3'b001, 1));
            else            applyStimulus(0, 6'b000000, 0, 0, 0, 0, loadi(1));
        end
        applyStimulus(0, 6'b001000, 0, 0, 0, 0, nop(1));
        applyStimulus(0, 6'b000111, 0, 0, 0, 0, nop(1));
        // reset overrides a step request from HALTED
        applyStimulus(1, 6'b100000, 0, 0, 0, 1, rstv());
        applyStimulus(0, 6'b100100, 0, 0, 0, 0, alu(3'b001, 0));
        applyStimulus(0, 6'b100100, 0, 0, 0, 0, alu(3'b001, 0));
        // 17 instructions after reset; the 4-bit counter shows 1 on the 18th cycle
        applyStimulus(1, 6'b100100, 0, 0, 0, 0, rstv());
        for (int i = 0; i < 18; i++) applyStimulus(0, 6'b100100, 0, 0, 0, 0, alu(3'b001, 0));

        @(negedge clk);
        #1;
        total++;
        if (sb_q.size() != 0) begin
            bad++;
            $display("[TB] FAIL drain: got %0d pending want 0", sb_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Watchdog so the run always ends
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout want finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/control_unit.md
CONTROL_UNIT -- requirements
Module: control_unit

Interface
REQ-001 Parameter CNT_W, default 16, width of the retired-instruction counter.
REQ-002 clk  input  1  rising-edge clock.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 opcode  input  6  instruction bits [15:10] from the datapath.
REQ-005 z  input  1  registered zero flag from the datapath.
REQ-006 dbg_halt, dbg_run, dbg_step  input  1 each  single-cycle debug request pulses.
REQ-007 s_inc  output  1  1 selects PC+1, 0 selects the jump target.
REQ-008 s_inm  output  1  1 selects the immediate for the register write data.
REQ-009 we3, wez  output  1 each  register-file write enable and zero-flag write enable.
REQ-010 op_alu  output  3  ALU operation.
REQ-011 pc_en  output  1  PC load enable.
REQ-012 halted  output  1  high while the FSM is in HALTED.
REQ-013 illegal  output  1  sticky undefined-opcode flag.
REQ-014 retired  output  CNT_W  retired-instruction count (only when CONTROL_UNIT_RETIRE_CNT_EN is defined).

Function
REQ-015 Decode SHALL be combinational from opcode and z; the instruction SHALL execute in the same cycle it is presented.
REQ-016 Opcode 1ooo_xx (ALU): op_alu = opcode[4:2], we3=1, wez=1, s_inm=0, s_inc=1.
REQ-017 Opcode 0000_xx (LOADI): we3=1, s_inm=1, wez=0, s_inc=1.
REQ-018 Opcodes 000100 J, 000101 JZ, 000110 JNZ: s_inc=0 when unconditional, when z=1 for JZ, or when z=0 for JNZ; otherwise s_inc=1; we3=wez=0.
REQ-019 Opcode 000111 (HALT): s_inc=1, pc_en=1, and the FSM SHALL enter HALTED next cycle, so the PC points past the HALT.
REQ-020 Opcodes 001xxx and 01xxxx: execute as a NOP (s_inc=1, no writes) and set illegal; illegal SHALL clear only on reset.
REQ-021 The FSM SHALL have states RUN, HALTED and STEP.
REQ-022 RUN: pc_en=1; enables follow decode every cycle.
REQ-023 HALTED: pc_en=0, we3=0, wez=0, s_inc=1, s_inm=0, op_alu=0.
REQ-024 HALTED + dbg_run -> RUN. HALTED + dbg_step -> STEP. If both pulse together, dbg_run SHALL win.
REQ-025 STEP: exactly one instruction executes as in RUN, then the state returns to HALTED regardless of the opcode; debug pulses in STEP SHALL be ignored.
REQ-026 RUN + dbg_halt: the current-cycle instruction SHALL complete, then the state goes to HALTED.
REQ-027 A HALT opcode together with dbg_halt SHALL yield a single transition to HALTED.
REQ-028 dbg_halt in HALTED, and dbg_run or dbg_step in RUN, SHALL have no effect.

Reset
REQ-029 While reset=1: state=RUN, pc_en=0, we3=0, wez=0, s_inc=1, s_inm=0, op_alu=0, halted=0, illegal=0, retired=0.
REQ-030 Reset SHALL override any state or debug pulse in the same cycle; execution resumes in RUN on the first cycle after reset deasserts.

Configuration
REQ-031 With CONTROL_UNIT_RETIRE_CNT_EN defined: retired increments by 1 in every cycle with pc_en=1 and reset=0, and wraps from all-ones to 0.
REQ-032 Without CONTROL_UNIT_RETIRE_CNT_EN: the retired port and its counter SHALL be absent, and all other behaviour SHALL be identical.

Structure
REQ-033 The shared package SHALL hold the opcode constants (OP_ALU prefix, OP_LOADI prefix, OP_J, OP_JZ, OP_JNZ, OP_HALT) and the FSM state encoding.
REQ-034 The design SHALL contain one sub-module, cu_decode: the combinational opcode/z to control-vector decoder. FSM gating and the counter stay in control_unit.

Verification
REQ-035 Reset held 3 cycles, opcode=100100 -> all enables 0 during reset; first cycle after reset: we3=1, wez=1, op_alu=001, pc_en=1.
REQ-036 opcode=000101 with z=1 -> s_inc=0; with z=0 -> s_inc=1; opcode=000110 with z=0 -> s_inc=0; we3=wez=0 in all cases.
REQ-037 HALT executed -> pc_en=1 that cycle, then halted=1 and pc_en=0 while opcode toggles through ALU values for 5 cycles, with we3 held 0.
REQ-038 In HALTED, dbg_step with opcode=000000 -> exactly one cycle of we3=1, s_inm=1, pc_en=1, then halted=1 again; retired +1.
REQ-039 In HALTED, dbg_run and dbg_step in the same cycle -> RUN, with pc_en=1 on consecutive cycles.
REQ-040 opcode=010011 -> illegal=1 and stays 1 over 10 later legal instructions until reset; with the macro defined and CNT_W=4, 17 retired instructions -> retired=1.
